// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch entries carry the instruction together with the PC it was read from.
package fetch_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int BUF_DEPTH  = 2;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries with flush.
// The head register keeps its last value after the FIFO drains.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] din,
    output logic [1:0]  count,
    output logic [31:0] head
);
    fetch_entry_t e0;
    fetch_entry_t e1;

    assign head = e0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd2) begin
                e0 <= e1;
                e1 <= din;
            end else begin
                e0 <= din;
            end
        end else if (push) begin
            if (count == 2'd0) e0 <= din;
            else               e1 <= din;
            count <= count + 2'd1;
        end else if (pop) begin
            if (count == 2'd2) e0 <= e1;
            count <= count - 2'd1;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to instruction memory and
// buffers returned words for decode behind a valid/ready handshake.
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] im_address,
    output logic        im_read_enable,
    output logic        im_write_enable,
    output logic [15:0] im_data_in,
    input  logic [15:0] im_data_out,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        dec_ready,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc
);
    fetch_state_t state;
    logic [15:0] pc;
    logic [15:0] inflight_pc;
    logic        inflight;
    logic        issue;
    logic        pop;
    logic        push;
    logic [1:0]  count;
    logic [2:0]  occupancy;
    logic [31:0] head;
    fetch_entry_t head_e;
    fetch_entry_t din_e;

    assign pop       = instr_valid && dec_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // The target read goes out during the redirect cycle so that it
    // lands in the buffer two edges after the branch.
    assign issue = (state == RUN || state == REDIRECT)
                && !branch_taken
                && (occupancy < 3'(BUF_DEPTH));
    assign push  = inflight && !branch_taken;

    assign din_e.pc    = inflight_pc;
    assign din_e.instr = im_data_out;
    assign head_e      = head;

    assign im_address      = pc;
    assign im_read_enable  = issue;
    assign im_write_enable = 1'b0;
    assign im_data_in      = '0;
    assign instr_valid     = (count != 2'd0);
    assign instr           = head_e.instr;
    assign instr_pc        = head_e.pc;

    fetch_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .din   (din_e),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (branch_taken) begin
                pc    <= {branch_target[15:1], 1'b0};
                state <= REDIRECT;
            end else begin
                if (issue) pc <= pc + PC_STEP;
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a word-array memory
// model and a program-order reference for the delivered instruction stream.
module tb_instruction_fetch_unit;
    logic        clk;
    logic        rst;
    logic [15:0] im_address;
    logic        im_read_enable;
    logic        im_write_enable;
    logic [15:0] im_data_in;
    logic [15:0] im_data_out;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        dec_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    logic [15:0] mem [0:32767];
    int checks;
    int failures;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .im_address      (im_address),
        .im_read_enable  (im_read_enable),
        .im_write_enable (im_write_enable),
        .im_data_in      (im_data_in),
        .im_data_out     (im_data_out),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .dec_ready       (dec_ready),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (im_read_enable) im_data_out <= mem[im_address[15:1]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        dec_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_ready = 1'b1;
        branch_taken = 1'b0;
        branch_target = '0;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
            failures++;
            $display("FAIL reset_out valid=%b instr=%h pc=%h want 0/0000/0000",
                     instr_valid, instr, instr_pc);
        end
        checks++;
        if (im_read_enable !== 1'b0 || im_address !== 16'h0
            || im_write_enable !== 1'b0 || im_data_in !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem re=%b addr=%h we=%b din=%h want 0/0000/0/0000",
                     im_read_enable, im_address, im_write_enable, im_data_in);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge1 valid=%b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge2 valid=%b want 0", instr_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ep;
            logic [15:0] ei;
            ep = 16'(2 * k);
            ei = (k == 0) ? 16'h1111 : (k == 1) ? 16'h2222 : 16'h3333;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== ei) begin
                failures++;
                $display("FAIL reset_seq%0d valid=%b pc=%h instr=%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, ep, ei);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        tick();
        tick();
        dec_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0004
            || im_read_enable !== 1'b0 || im_address !== 16'h0008) begin
            failures++;
            $display("FAIL bp_full valid=%b pc=%h re=%b addr=%h want 1/0004/0/0008",
                     instr_valid, instr_pc, im_read_enable, im_address);
        end
        dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] ep;
            ep = 16'(4 + 2 * k);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== mem[ep[15:1]]) begin
                failures++;
                $display("FAIL bp_drain%0d valid=%b pc=%h instr=%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, ep, mem[ep[15:1]]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        do_reset();
        dec_ready = 1'b0;
        tick();
        tick();
        branch_taken = 1'b1;
        branch_target = 16'h0041;
        tick();
        branch_taken = 1'b0;
        dec_ready = 1'b1;
        checks++;
        if (instr_valid !== 1'b0 || im_address !== 16'h0040) begin
            failures++;
            $display("FAIL br_flush valid=%b addr=%h want 0/0040", instr_valid, im_address);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL br_dead valid=%b want 0", instr_valid);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] ep;
            ep = 16'(16'h0040 + 2 * k);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== mem[ep[15:1]]) begin
                failures++;
                $display("FAIL br_target%0d valid=%b pc=%h instr=%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, ep, mem[ep[15:1]]);
            end
            tick();
        end
    endtask

    task automatic test_branch_pop();
        do_reset();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
            failures++;
            $display("FAIL bpop_head valid=%b pc=%h want 1/0000", instr_valid, instr_pc);
        end
        branch_taken = 1'b1;
        branch_target = 16'h0123;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL bpop_flush valid=%b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL bpop_squash valid=%b pc=%h want 0", instr_valid, instr_pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0122) begin
            failures++;
            $display("FAIL bpop_target valid=%b pc=%h want 1/0122", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1'b1;
        branch_target = 16'hFFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ep;
            ep = 16'(32'hFFFC + 2 * k);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== mem[ep[15:1]]) begin
                failures++;
                $display("FAIL wrap%0d valid=%b pc=%h instr=%h want 1/%h/%h",
                         k, instr_valid, instr_pc, instr, ep, mem[ep[15:1]]);
            end
            tick();
        end
    endtask

    task automatic test_idle_branch();
        rst = 1'b1;
        dec_ready = 1'b1;
        tick();
        rst = 1'b0;
        branch_taken = 1'b1;
        branch_target = 16'h0100;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || im_address !== 16'h0100) begin
            failures++;
            $display("FAIL idle_br valid=%b addr=%h want 0/0100", instr_valid, im_address);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin
            failures++;
            $display("FAIL idle_br_target valid=%b pc=%h want 1/0100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || im_address !== 16'h0000 || im_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL areset valid=%b addr=%h re=%b want 0/0000/0",
                     instr_valid, im_address, im_read_enable);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_early valid=%b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h1111) begin
            failures++;
            $display("FAIL areset_first valid=%b pc=%h instr=%h want 1/0000/1111",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic        prev_branch;
        int          stall;
        int          accepted;
        do_reset();
        exp_pc = 16'h0000;
        prev_branch = 1'b0;
        stall = 0;
        accepted = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            dec_ready = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 99) < 5);
            branch_target = 16'($urandom);
            if (prev_branch) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush cyc=%0d valid=%b want 0", cyc, instr_valid);
                end
            end
            if (instr_valid && dec_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc[15:1]]) begin
                    failures++;
                    $display("FAIL rnd_stream cyc=%0d pc=%h instr=%h want %h/%h",
                             cyc, instr_pc, instr, exp_pc, mem[exp_pc[15:1]]);
                end
                exp_pc = exp_pc + 16'd2;
                accepted++;
            end
            stall = (dec_ready && !instr_valid) ? stall + 1 : 0;
            if (branch_taken) begin
                exp_pc = {branch_target[15:1], 1'b0};
                stall = 0;
            end
            if (stall > 3) begin
                checks++;
                failures++;
                $display("FAIL rnd_stall cyc=%0d stalled=%0d want <=3", cyc, stall);
                stall = 0;
            end
            prev_branch = branch_taken;
            tick();
        end
        branch_taken = 1'b0;
        checks++;
        if (accepted < 200) begin
            failures++;
            $display("FAIL rnd_progress accepted=%0d want >=200", accepted);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        dec_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        test_reset();
        test_back_pressure();
        test_branch();
        test_branch_pop();
        test_wrap();
        test_idle_branch();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
